// File: rtl/hex_stream_pkg.sv
// Shared types and helpers for the hex character streamer: FSM state encoding,
// the carriage-return code and the nibble-to-ASCII conversion.
package hex_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2,
    EOL  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;

  // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n - 4'd10};
  endfunction

endpackage

// File: rtl/hex_char_streamer.sv
// Streams one accepted word as uppercase ASCII hex characters, MS nibble first,
// paced by GAP_CYCLES idle cycles. Define HEX_STREAM_EOL_EN to append 0x0D per word.
module hex_char_streamer
  import hex_stream_pkg::*;
#(
  parameter int WORD_W     = 64,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              write_en,
  output logic [7:0]        data,
  output logic              busy,
  output state_t            fsm_state
);

  localparam int NIBBLES = WORD_W / 4;
  localparam int NW      = $clog2(NIBBLES + 1);
  localparam int GW      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [NW-1:0] NIB_LOAD = NW'(NIBBLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] shift_next;
  logic [NW-1:0]     nib_cnt;
  logic [NW-1:0]     nib_next;
  logic [GW-1:0]     gap_cnt;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, so in_valid while busy is simply not taken.
  assign in_ready   = (state == IDLE);
  assign busy       = !in_ready;
  assign fsm_state  = state;
  assign shift_next = shift_reg << 4;
  assign nib_next   = nib_cnt - NW'(1);

  // write_en/data are registered on the transition into a strobing state, so
  // they are valid in exactly the cycle the FSM sits in EMIT or EOL.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      nib_cnt   <= '0;
      gap_cnt   <= '0;
      write_en  <= 1'b0;
      data      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          write_en <= 1'b0;
          if (in_valid) begin
            shift_reg <= in_word;
            nib_cnt   <= NIB_LOAD;
            write_en  <= 1'b1;
            data      <= nibble_to_ascii(in_word[WORD_W-1 -: 4]);
            state     <= EMIT;
          end
        end
        EMIT: begin
          shift_reg <= shift_next;
          nib_cnt   <= nib_next;
          if (nib_next != '0) begin
            if (GAP_CYCLES == 0) begin
              data <= nibble_to_ascii(shift_next[WORD_W-1 -: 4]);
            end else begin
              write_en <= 1'b0;
              gap_cnt  <= GAP_LOAD;
              state    <= GAP;
            end
          end else begin
`ifdef HEX_STREAM_EOL_EN
            if (GAP_CYCLES == 0) begin
              data  <= ASCII_CR;
              state <= EOL;
            end else begin
              write_en <= 1'b0;
              gap_cnt  <= GAP_LOAD;
              state    <= GAP;
            end
`else
            write_en <= 1'b0;
            state    <= IDLE;
`endif
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            write_en <= 1'b1;
`ifdef HEX_STREAM_EOL_EN
            if (nib_cnt == '0) begin
              data  <= ASCII_CR;
              state <= EOL;
            end else begin
              data  <= nibble_to_ascii(shift_reg[WORD_W-1 -: 4]);
              state <= EMIT;
            end
`else
            data  <= nibble_to_ascii(shift_reg[WORD_W-1 -: 4]);
            state <= EMIT;
`endif
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
`ifdef HEX_STREAM_EOL_EN
        EOL: begin
          write_en <= 1'b0;
          state    <= IDLE;
        end
`endif
        default: begin
          write_en <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_char_streamer.sv
// Bench for hex_char_streamer: a 64-bit/gap-4 instance and an 8-bit/gap-0 instance,
// directed words, scoreboard queues of {cycle, char} drained by per-instance monitors.
module tb_hex_char_streamer;
  import hex_stream_pkg::*;

  localparam int WA = 64;
  localparam int GA = 4;
  localparam int WB = 8;
  localparam int GB = 0;
`ifdef HEX_STREAM_EOL_EN
  localparam bit EOL_ON = 1'b1;
`else
  localparam bit EOL_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_a, valid_a, rdy_a, we_a, busy_a;
  logic [WA-1:0] word_a;
  logic [7:0]    data_a;
  state_t        state_a;
  logic          rst_b, valid_b, rdy_b, we_b, busy_b;
  logic [WB-1:0] word_b;
  logic [7:0]    data_b;
  state_t        state_b;

  hex_char_streamer #(.WORD_W(WA), .GAP_CYCLES(GA)) dut_a (
    .clock(clk), .reset(rst_a), .in_valid(valid_a), .in_ready(rdy_a), .in_word(word_a),
    .write_en(we_a), .data(data_a), .busy(busy_a), .fsm_state(state_a));

  hex_char_streamer #(.WORD_W(WB), .GAP_CYCLES(GB)) dut_b (
    .clock(clk), .reset(rst_b), .in_valid(valid_b), .in_ready(rdy_b), .in_word(word_b),
    .write_en(we_b), .data(data_b), .busy(busy_b), .fsm_state(state_b));

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [39:0] exp_a[$];
  logic [39:0] exp_b[$];
  logic [39:0] e_a, e_b;
  int   seen_a = 0;
  logic prev_we_a = 1'b0;
  string hex_chars = "0123456789ABCDEF";

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int id, input logic [63:0] w, input int acc);
    int n = (id == 0) ? WA / 4 : WB / 4;
    int g = (id == 0) ? GA : GB;
    logic [3:0] nib;
    logic [7:0] ch;
    for (int k = 0; k < n; k++) begin
      nib = w[(n - 1 - k) * 4 +: 4];
      ch  = hex_chars[nib];
      if (id == 0) exp_a.push_back({32'(acc + 1 + k * (g + 1)), ch});
      else         exp_b.push_back({32'(acc + 1 + k * (g + 1)), ch});
    end
    if (EOL_ON) begin
      if (id == 0) exp_a.push_back({32'(acc + 1 + n * (g + 1)), 8'h0D});
      else         exp_b.push_back({32'(acc + 1 + n * (g + 1)), 8'h0D});
    end
  endtask

  function automatic int next_acc(input int id, input int acc);
    int n = (id == 0) ? WA / 4 : WB / 4;
    int g = (id == 0) ? GA : GB;
    return EOL_ON ? acc + 2 + n * (g + 1) : acc + 2 + (n - 1) * (g + 1);
  endfunction

  // monitors
  always @(negedge clk) begin
    if (!rst_a) begin
      prev_we_a <= 1'b0;
    end else begin
      check32("busy_a", 32'(busy_a), 32'(!rdy_a));
      if (we_a) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_a actual=%0h required=no strobe (cycle %0d)", data_a, cyc);
        end else begin
          e_a = exp_a.pop_front();
          check32("char_a", 32'(data_a), 32'(e_a[7:0]));
          check32("cycle_a", 32'(cyc), e_a[39:8]);
        end
        if (prev_we_a) begin
          checks++; errors++;
          $display("FAIL back_to_back_a actual=two strobes required=gap (cycle %0d)", cyc);
        end
        seen_a <= seen_a + 1;
      end
      prev_we_a <= we_a;
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      check32("busy_b", 32'(busy_b), 32'(!rdy_b));
      if (we_b) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_b actual=%0h required=no strobe (cycle %0d)", data_b, cyc);
        end else begin
          e_b = exp_b.pop_front();
          check32("char_b", 32'(data_b), 32'(e_b[7:0]));
          check32("cycle_b", 32'(cyc), e_b[39:8]);
        end
      end
    end
  end

  // drivers
  task automatic send(input int id, input logic [63:0] w, input bit hold, input bit toggle,
                      output int acc);
    int waited = 0;
    bit rdy;
    @(negedge clk);
    rdy = (id == 0) ? rdy_a : rdy_b;
    while (!rdy && waited < 300) begin
      if (toggle) begin
        if (id == 0) word_a = {$urandom, $urandom};
        else         word_b = 8'($urandom);
      end
      @(negedge clk);
      waited++;
      rdy = (id == 0) ? rdy_a : rdy_b;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=in_ready low required=high (dut %0d)", id);
      acc = -1;
      return;
    end
    acc = cyc;
    if (id == 0) begin valid_a = 1'b1; word_a = w; end
    else begin valid_b = 1'b1; word_b = w[7:0]; end
    push_exp(id, w, acc);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (id == 0) valid_a = 1'b0;
      else         valid_b = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    #2;
    while (exp_a.size() != 0) begin
      e_a = exp_a.pop_front();
      checks++; errors++;
      $display("FAIL missing_a actual=none required=%0h at cycle %0d", e_a[7:0], e_a[39:8]);
    end
    while (exp_b.size() != 0) begin
      e_b = exp_b.pop_front();
      checks++; errors++;
      $display("FAIL missing_b actual=none required=%0h at cycle %0d", e_b[7:0], e_b[39:8]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, t, target;
    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    word_a = '0; word_b = '0;
    repeat (2) @(negedge clk);
    check32("rst_we_a", 32'(we_a), 32'd0);
    check32("rst_data_a", 32'(data_a), 32'h00);
    check32("rst_ready_a", 32'(rdy_a), 32'd1);
    check32("rst_busy_a", 32'(busy_a), 32'd0);
    check32("rst_state_a", 32'(state_a), 32'(IDLE));
    check32("rst_we_b", 32'(we_b), 32'd0);
    check32("rst_data_b", 32'(data_b), 32'h00);
    check32("rst_ready_b", 32'(rdy_b), 32'd1);
    check32("rst_state_b", 32'(state_b), 32'(IDLE));
    rst_a = 1'b1; rst_b = 1'b1;

    // counting word with full gap; in_ready returns exactly on schedule
    send(0, 64'h0123456789ABCDEF, 1'b0, 1'b0, acc);
    t = next_acc(0, acc);
    wait_cyc(t - 1);
    check32("ready_early_a", 32'(rdy_a), 32'd0);
    wait_cyc(t);
    check32("ready_back_a", 32'(rdy_a), 32'd1);
    drain();

    send(0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, acc);
    t = next_acc(0, acc);
    wait_cyc(t - 1);
    check32("ready_early_f", 32'(rdy_a), 32'd0);
    wait_cyc(t);
    check32("ready_back_f", 32'(rdy_a), 32'd1);
    drain();

    // zero-gap instance
    send(1, 64'hA5, 1'b0, 1'b0, acc);
    t = next_acc(1, acc);
    wait_cyc(t - 1);
    check32("ready_early_b", 32'(rdy_b), 32'd0);
    wait_cyc(t);
    check32("ready_back_b", 32'(rdy_b), 32'd1);
    drain();

    // in_valid held: second word taken on first IDLE cycle, in_word churn ignored
    send(0, 64'hDEADBEEFCAFEF00D, 1'b1, 1'b0, acc);
    send(0, 64'h0011223344556677, 1'b0, 1'b1, acc2);
    check32("accept2_a", 32'(acc2), 32'(next_acc(0, acc)));
    drain();

    send(1, 64'h00, 1'b1, 1'b0, acc);
    send(1, 64'hFF, 1'b1, 1'b1, acc2);
    check32("accept2_b", 32'(acc2), 32'(next_acc(1, acc)));
    send(1, 64'h3C, 1'b0, 1'b1, acc);
    check32("accept3_b", 32'(acc), 32'(next_acc(1, acc2)));
    drain();

    // reset pulse right after the third character
    target = seen_a + 3;
    send(0, 64'h13579BDF02468ACE, 1'b0, 1'b0, acc);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (seen_a >= target) break;
    end
    check32("third_char_seen", 32'(seen_a), 32'(target));
    rst_a = 1'b0;
    #1;
    check32("midrst_we", 32'(we_a), 32'd0);
    check32("midrst_data", 32'(data_a), 32'h00);
    check32("midrst_ready", 32'(rdy_a), 32'd1);
    exp_a.delete();
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    check32("postrst_ready", 32'(rdy_a), 32'd1);
    check32("postrst_busy", 32'(busy_a), 32'd0);
    send(0, 64'h0, 1'b0, 1'b0, acc);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
